// File: rtl/mod_updown_counter.sv
// -----------------------------------------------------------------------------
// mod_updown_counter
//
// Purpose:
//   Parameterised up/down counter over the range 0..MAX_VAL. On reaching a
//   boundary it either wraps to the opposite end (SATURATE=0) or holds
//   (SATURATE=1). Every boundary hit produces a one-cycle wrap pulse and sets
//   a sticky overflow flag. Per-edge action priority is clr > load > en.
//
// Parameters:
//   WIDTH    - counter width in bits (2..32)
//   MAX_VAL  - highest count value (1..2^WIDTH-1)
//   SATURATE - 0: wrap at the boundary, 1: hold at the boundary
//
// Ports:
//   clk        in   clock, rising edge
//   reset      in   asynchronous reset, active-high
//   clr        in   synchronous clear (count, wrap, ovf_sticky -> 0)
//   load       in   synchronous load of min(load_val, MAX_VAL)
//   load_val   in   value to load, WIDTH bits
//   en         in   count enable
//   up         in   direction, 1 = increment, 0 = decrement
//   count      out  registered count value
//   tc         out  terminal count, combinational from count and up
//   wrap       out  registered one-cycle boundary-event pulse
//   ovf_sticky out  registered sticky boundary-event flag
// -----------------------------------------------------------------------------
module mod_updown_counter #(
  parameter int              WIDTH    = 8,
  parameter longint unsigned MAX_VAL  = 255,
  parameter bit              SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  input  logic             up,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             wrap,
  output logic             ovf_sticky
);

  // MAX_VAL is carried as a 64-bit parameter so 2^32-1 is representable;
  // all arithmetic below is done at WIDTH bits.
  localparam logic [WIDTH-1:0] C_MAX = WIDTH'(MAX_VAL);
  localparam logic [WIDTH-1:0] C_ONE = WIDTH'(1);

  logic [WIDTH-1:0] r_count;
  logic             r_wrap;
  logic             r_ovf;

  logic             w_at_max;
  logic             w_at_zero;
  logic             w_tc;
  logic             w_event;
  logic [WIDTH-1:0] w_count_nxt;
  logic             w_wrap_nxt;
  logic             w_ovf_nxt;

  // Clamp a loaded value into the legal range.
  function automatic logic [WIDTH-1:0] f_clamp_load(input logic [WIDTH-1:0] v);
    return (v > C_MAX) ? C_MAX : v;
  endfunction

  // Increment with boundary handling. The comparison is done before the
  // add so MAX_VAL = 2^WIDTH-1 never needs a carry bit.
  function automatic logic [WIDTH-1:0] f_step_up(input logic [WIDTH-1:0] c);
    if (c >= C_MAX) begin
      return SATURATE ? C_MAX : '0;
    end
    return c + C_ONE;
  endfunction

  // Decrement with boundary handling; an out-of-range value (never reached
  // in normal operation) is pulled back to MAX_VAL.
  function automatic logic [WIDTH-1:0] f_step_down(input logic [WIDTH-1:0] c);
    if (c == '0) begin
      return SATURATE ? '0 : C_MAX;
    end
    if (c > C_MAX) begin
      return C_MAX;
    end
    return c - C_ONE;
  endfunction

  assign w_at_max  = (r_count >= C_MAX);
  assign w_at_zero = (r_count == '0);

  // Terminal count looks only at the current direction, not at en, so a
  // direction change is reflected immediately.
  assign w_tc    = up ? w_at_max : w_at_zero;
  assign w_event = en & w_tc;

  always_comb begin
    w_count_nxt = r_count;
    w_wrap_nxt  = 1'b0;
    w_ovf_nxt   = r_ovf;
    if (clr) begin
      w_count_nxt = '0;
      w_ovf_nxt   = 1'b0;
    end else if (load) begin
      w_count_nxt = f_clamp_load(load_val);
    end else if (en) begin
      w_count_nxt = up ? f_step_up(r_count) : f_step_down(r_count);
      w_wrap_nxt  = w_event;
      if (w_event) begin
        w_ovf_nxt = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
      r_wrap  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_count <= w_count_nxt;
      r_wrap  <= w_wrap_nxt;
      r_ovf   <= w_ovf_nxt;
    end
  end

  assign count      = r_count;
  assign tc         = w_tc;
  assign wrap       = r_wrap;
  assign ovf_sticky = r_ovf;

endmodule

// File: tb/tb_mod_updown_counter.sv
// -----------------------------------------------------------------------------
// tb_mod_updown_counter
//
// Three counters share the control inputs:
//   u_w : WIDTH=4, MAX_VAL=9,   SATURATE=0
//   u_s : WIDTH=4, MAX_VAL=9,   SATURATE=1
//   u_f : WIDTH=8, MAX_VAL=255, SATURATE=0
// A range-based reference model tracks all three. Directed table rows,
// hand-written corner sequences and random traffic are all checked.
// -----------------------------------------------------------------------------
module tb_mod_updown_counter;

  logic       clk = 1'b0;
  logic       reset;
  logic       clr, load, en, up;
  logic [3:0] lv4;
  logic [7:0] lv8;

  logic [3:0] c_w, c_s;
  logic [7:0] c_f;
  logic       tc_w, tc_s, tc_f;
  logic       wr_w, wr_s, wr_f;
  logic       ov_w, ov_s, ov_f;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mod_updown_counter #(.WIDTH(4), .MAX_VAL(9), .SATURATE(1'b0)) u_w (
    .clk(clk), .reset(reset), .clr(clr), .load(load), .load_val(lv4),
    .en(en), .up(up), .count(c_w), .tc(tc_w), .wrap(wr_w), .ovf_sticky(ov_w));

  mod_updown_counter #(.WIDTH(4), .MAX_VAL(9), .SATURATE(1'b1)) u_s (
    .clk(clk), .reset(reset), .clr(clr), .load(load), .load_val(lv4),
    .en(en), .up(up), .count(c_s), .tc(tc_s), .wrap(wr_s), .ovf_sticky(ov_s));

  mod_updown_counter #(.WIDTH(8), .MAX_VAL(255), .SATURATE(1'b0)) u_f (
    .clk(clk), .reset(reset), .clr(clr), .load(load), .load_val(lv8),
    .en(en), .up(up), .count(c_f), .tc(tc_f), .wrap(wr_f), .ovf_sticky(ov_f));

  // ---------------- reference model ----------------
  int MX [3] = '{9, 9, 255};
  bit SAT[3] = '{1'b0, 1'b1, 1'b0};
  int m_cnt [3];
  bit m_wrap[3];
  bit m_ovf [3];

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_cnt[i] = 0; m_wrap[i] = 0; m_ovf[i] = 0;
    end
  endtask

  // Counts live on the integer range [0, MX]; a step that would leave it is
  // a boundary event, resolved by modulo (wrap) or clamping (saturate).
  task automatic model_step();
    int v, t;
    for (int i = 0; i < 3; i++) begin
      if (clr) begin
        m_cnt[i] = 0; m_wrap[i] = 0; m_ovf[i] = 0;
      end else if (load) begin
        v = (i < 2) ? int'(lv4) : int'(lv8);
        m_cnt[i]  = (v > MX[i]) ? MX[i] : v;
        m_wrap[i] = 0;
      end else if (en) begin
        t = m_cnt[i] + (up ? 1 : -1);
        if (t < 0 || t > MX[i]) begin
          m_wrap[i] = 1;
          m_ovf[i]  = 1;
          if (SAT[i]) m_cnt[i] = (t < 0) ? 0 : MX[i];
          else        m_cnt[i] = (t + MX[i] + 1) % (MX[i] + 1);
        end else begin
          m_cnt[i]  = t;
          m_wrap[i] = 0;
        end
      end else begin
        m_wrap[i] = 0;
      end
    end
  endtask

  // ---------------- checking ----------------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  function automatic bit exp_tc(input int i);
    return up ? (m_cnt[i] == MX[i]) : (m_cnt[i] == 0);
  endfunction

  task automatic check_all(input string tag);
    chk({tag, " w.count"}, c_w,  m_cnt[0]);
    chk({tag, " w.tc"},    tc_w, exp_tc(0));
    chk({tag, " w.wrap"},  wr_w, m_wrap[0]);
    chk({tag, " w.ovf"},   ov_w, m_ovf[0]);
    chk({tag, " s.count"}, c_s,  m_cnt[1]);
    chk({tag, " s.tc"},    tc_s, exp_tc(1));
    chk({tag, " s.wrap"},  wr_s, m_wrap[1]);
    chk({tag, " s.ovf"},   ov_s, m_ovf[1]);
    chk({tag, " f.count"}, c_f,  m_cnt[2]);
    chk({tag, " f.tc"},    tc_f, exp_tc(2));
    chk({tag, " f.wrap"},  wr_f, m_wrap[2]);
    chk({tag, " f.ovf"},   ov_f, m_ovf[2]);
  endtask

  task automatic drive(input bit c, input bit l, input bit e, input bit u, input int v);
    clr = c; load = l; en = e; up = u; lv4 = 4'(v); lv8 = 8'(v);
  endtask

  // One clock edge: inputs are already stable; sample 1 time unit later.
  task automatic cycle(input string tag);
    @(posedge clk);
    model_step();
    #1;
    check_all(tag);
  endtask

  // Assert reset between edges, check before the next edge, hold it across
  // one edge, then release away from the edge.
  task automatic async_reset(input string tag);
    #2 reset = 1'b1;
    #1 model_reset();
    check_all({tag, " async"});
    @(posedge clk);
    #1 check_all({tag, " held"});
    #2 reset = 1'b0;
  endtask

  // ---------------- directed table (expectations for u_w) ----------------
  typedef struct {
    bit clr, load, en, up;
    int lv;
    int e_cnt;
    bit e_tc, e_wrap, e_ovf;
  } vec_t;

  vec_t tbl[$];

  initial begin
    vec_t r;
    string nm;

    reset = 1'b1;
    drive(0, 0, 0, 1, 0);

    // count 1..9 then wrap to 0
    for (int i = 1; i <= 9; i++)
      tbl.push_back('{0, 0, 1, 1, 0, i, (i == 9), 0, 0});
    tbl.push_back('{0, 0, 1, 1, 0,  0, 0, 1, 1});
    tbl.push_back('{0, 0, 1, 1, 0,  1, 0, 0, 1});  // wrap only for one cycle
    tbl.push_back('{0, 0, 1, 0, 0,  0, 1, 0, 1});  // direction change, no dead cycle
    tbl.push_back('{0, 0, 1, 0, 0,  9, 0, 1, 1});  // down-wrap to MAX_VAL
    tbl.push_back('{1, 1, 1, 1, 5,  0, 0, 0, 0});  // clr beats load and en
    tbl.push_back('{0, 1, 1, 1, 12, 9, 1, 0, 0});  // load beats en, clamped
    tbl.push_back('{0, 0, 0, 1, 3,  9, 1, 0, 0});  // load_val ignored, hold
    tbl.push_back('{0, 0, 1, 1, 3,  0, 0, 1, 1});
    tbl.push_back('{0, 1, 0, 0, 4,  4, 0, 0, 1});  // load keeps ovf_sticky
    tbl.push_back('{0, 0, 1, 0, 4,  3, 0, 0, 1});

    // reset state, with tc following direction
    #12;
    model_reset();
    check_all("reset up1");
    up = 1'b0;
    #1 check_all("reset up0");
    up = 1'b1;
    reset = 1'b0;

    foreach (tbl[k]) begin
      r = tbl[k];
      drive(r.clr, r.load, r.en, r.up, r.lv);
      nm = $sformatf("tbl%0d", k);
      cycle(nm);
      chk({nm, " w.count const"}, c_w,  r.e_cnt);
      chk({nm, " w.tc const"},    tc_w, r.e_tc);
      chk({nm, " w.wrap const"},  wr_w, r.e_wrap);
      chk({nm, " w.ovf const"},   ov_w, r.e_ovf);
    end

    // Saturate-down on u_s: load 2, then 4 down steps -> 2,1,0,0,0
    drive(0, 1, 0, 0, 2);
    cycle("sat load");
    chk("sat load s.count", c_s, 2);
    begin
      int exp_c[4] = '{1, 0, 0, 0};
      bit exp_wr[4] = '{0, 0, 1, 1};
      for (int i = 0; i < 4; i++) begin
        drive(0, 0, 1, 0, 0);
        nm = $sformatf("satdn%0d", i);
        cycle(nm);
        chk({nm, " s.count const"}, c_s,  exp_c[i]);
        chk({nm, " s.wrap const"},  wr_s, exp_wr[i]);
      end
    end
    chk("satdn s.ovf const", ov_s, 1);

    // Full range on u_f: 254 -> 255 -> 0 (wrap) -> reverse -> 255 (wrap)
    drive(1, 0, 0, 1, 0);
    cycle("full clr");
    drive(0, 1, 0, 1, 254);
    cycle("full load");
    chk("full load f.count", c_f, 254);
    drive(0, 0, 1, 1, 0);
    cycle("full up1");
    chk("full up1 f.count", c_f, 255);
    chk("full up1 f.wrap",  wr_f, 0);
    chk("full up1 f.tc",    tc_f, 1);
    cycle("full up2");
    chk("full up2 f.count", c_f, 0);
    chk("full up2 f.wrap",  wr_f, 1);
    drive(0, 0, 1, 0, 0);
    cycle("full dn");
    chk("full dn f.count", c_f, 255);
    chk("full dn f.wrap",  wr_f, 1);
    chk("full dn f.ovf",   ov_f, 1);

    // Async reset from count 7, then resume from 0
    drive(0, 1, 0, 1, 7);
    cycle("ar load");
    chk("ar load w.count", c_w, 7);
    drive(0, 0, 1, 1, 0);
    async_reset("ar");
    chk("ar w.count const", c_w, 0);
    chk("ar w.ovf const",   ov_w, 0);
    cycle("ar resume");
    chk("ar resume w.count", c_w, 1);

    // Random traffic against the model
    for (int n = 0; n < 600; n++) begin
      drive(($urandom_range(15) == 0), ($urandom_range(7) == 0),
            ($urandom_range(3) != 0), $urandom_range(1), $urandom_range(255));
      if ($urandom_range(63) == 0) async_reset($sformatf("rnd%0d", n));
      else                         cycle($sformatf("rnd%0d", n));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
